// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and helpers for the cascaded BCD counter.
//   bcd_digit_t : one packed BCD digit
//   BCD_MAX/MIN : digit range limits
//   bcd_clamp() : maps any 4-bit value onto the legal digit range (min(d, 9))
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit of the cascaded counter.
// Ports:
//   Clk       - clock, state updates on rising edge
//   Reset     - synchronous active-low reset, digit -> 0
//   Up        - 1 = increment, 0 = decrement on a step
//   StepIn    - ripple enable; digit moves one position when high
//   Load      - parallel load strobe (takes priority over StepIn)
//   LoadDigit - value to load, clamped to 9
//   Digit     - registered digit value
//   ChainOut  - digit sits at its terminal for the current direction
//               (9 when counting up, 0 when counting down)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Up,
  input  logic       StepIn,
  input  logic       Load,
  input  logic [3:0] LoadDigit,
  output logic [3:0] Digit,
  output logic       ChainOut
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;
  bcd_digit_t digit_cur;

  // An illegal stored value (10..15) behaves as 9 for both stepping and
  // the chain output, so the counter recovers on the next step.
  assign digit_cur = bcd_clamp(digit_q);

  always_comb begin
    digit_d = digit_q;
    if (Load) begin
      digit_d = bcd_clamp(LoadDigit);
    end else if (StepIn) begin
      if (Up) begin
        digit_d = (digit_cur == BCD_MAX) ? BCD_MIN : digit_cur + 4'd1;
      end else begin
        digit_d = (digit_cur == BCD_MIN) ? BCD_MAX : digit_cur - 4'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign Digit    = digit_q;
  assign ChainOut = Up ? (digit_cur == BCD_MAX) : (digit_cur == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit cascaded up/down BCD counter with parallel load
// and wrap-or-saturate behaviour at the terminal count.
// Parameters:
//   NDIGITS - number of digits (1..8)
//   WRAP    - 1 = roll over at terminal, 0 = hold at terminal
// Ports:
//   Clk      - clock
//   Reset    - synchronous active-low reset
//   Trigger  - local count enable
//   Cin      - carry/borrow from the lower-order instance
//   Up       - count direction, 1 = up
//   Load     - parallel load strobe, beats stepping
//   LoadData - BCD value to load (digit 0 in [3:0]), digits > 9 clamp to 9
//   DataOut  - registered BCD count
//   Cout     - combinational carry/borrow out, high when a step hits terminal
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int WRAP    = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Trigger,
  input  logic                   Cin,
  input  logic                   Up,
  input  logic                   Load,
  input  logic [4*NDIGITS-1:0]   LoadData,
  output logic [4*NDIGITS-1:0]   DataOut,
  output logic                   Cout
);

  logic               step;
  logic               at_terminal;
  logic               sat_hold;
  logic [NDIGITS-1:0] en;
  logic [NDIGITS-1:0] chain;

  // Trigger and Cin together still produce a single count.
  assign step        = (Trigger | Cin) & ~Load;
  assign at_terminal = &chain;

  // In saturate mode a step at the terminal is swallowed before it reaches
  // the digits, so the whole count simply holds.
  assign sat_hold    = (WRAP == 0) && at_terminal;

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        assign en[gi] = step & ~sat_hold;
      end else begin : g_rest
        // Ripple enable: a digit moves only when every lower digit is at
        // its terminal for the current direction.
        assign en[gi] = en[gi-1] & chain[gi-1];
      end

      bcd_digit u_digit (
        .Clk       (Clk),
        .Reset     (Reset),
        .Up        (Up),
        .StepIn    (en[gi]),
        .Load      (Load),
        .LoadDigit (LoadData[4*gi +: 4]),
        .Digit     (DataOut[4*gi +: 4]),
        .ChainOut  (chain[gi])
      );
    end
  endgenerate

  // Reset gating keeps Cout low during reset regardless of register state.
  assign Cout = Reset & step & at_terminal;

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: self-checking bench for bcd_counter_n.
// Two 2-digit instances (wrap and saturate) share one stimulus; two 1-digit
// instances are chained through Cout->Cin. The reference model tracks each
// counter as a plain decimal integer.
module tb_bcd_counter_n;

  logic       clk;
  logic       rst_n;
  logic       trig;
  logic       cin;
  logic       up;
  logic       load;
  logic [7:0] ld_data;
  logic [7:0] out_w;
  logic [7:0] out_s;
  logic       cout_w;
  logic       cout_s;

  logic       c_rst_n;
  logic       c_trig;
  logic [3:0] lo_out;
  logic [3:0] hi_out;
  logic       lo_cout;
  logic       hi_cout;

  int checks   = 0;
  int failures = 0;
  int m_w;
  int m_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_counter_n #(.NDIGITS(2), .WRAP(1)) dut_w (
    .Clk(clk), .Reset(rst_n), .Trigger(trig), .Cin(cin), .Up(up),
    .Load(load), .LoadData(ld_data), .DataOut(out_w), .Cout(cout_w)
  );

  bcd_counter_n #(.NDIGITS(2), .WRAP(0)) dut_s (
    .Clk(clk), .Reset(rst_n), .Trigger(trig), .Cin(cin), .Up(up),
    .Load(load), .LoadData(ld_data), .DataOut(out_s), .Cout(cout_s)
  );

  bcd_counter_n #(.NDIGITS(1), .WRAP(1)) dut_lo (
    .Clk(clk), .Reset(c_rst_n), .Trigger(c_trig), .Cin(1'b0), .Up(1'b1),
    .Load(1'b0), .LoadData(4'h0), .DataOut(lo_out), .Cout(lo_cout)
  );

  bcd_counter_n #(.NDIGITS(1), .WRAP(1)) dut_hi (
    .Clk(clk), .Reset(c_rst_n), .Trigger(1'b0), .Cin(lo_cout), .Up(1'b1),
    .Load(1'b0), .LoadData(4'h0), .DataOut(hi_out), .Cout(hi_cout)
  );

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic int model_next(int v, bit wrap, bit dir_up, bit stp);
    if (!stp) return v;
    if (dir_up) return (v == 99) ? (wrap ? 0 : 99) : v + 1;
    return (v == 0) ? (wrap ? 99 : 0) : v - 1;
  endfunction

  function automatic bit model_term(int v, bit dir_up);
    return dir_up ? (v == 99) : (v == 0);
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int load_value(logic [7:0] d);
    int t;
    int o;
    t = int'(d[7:4]);
    o = int'(d[3:0]);
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  task automatic drive(input logic r, input logic t, input logic c,
                       input logic u, input logic l, input logic [7:0] d);
    rst_n = r; trig = t; cin = c; up = u; load = l; ld_data = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checks++;
    if (cout_w !== 1'b0 || cout_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_cout got=%b/%b exp=0/0", cout_w, cout_s);
    end
    @(posedge clk); #1;
    m_w = 0; m_s = 0;
    checks++;
    if (out_w !== 8'h00 || out_s !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=00/00", out_w, out_s);
    end
    checks++;
    if (cout_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_cout_hold got=%b exp=0", cout_w);
    end
    $display("test_reset: DataOut=%h/%h", out_w, out_s);
  endtask

  task automatic test_count_up();
    bit ec;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ec = model_term(m_w, 1'b1);
      checks++;
      if (cout_w !== ec) begin
        failures++;
        $display("FAIL count_up_cout step=%0d got=%b exp=%b", i, cout_w, ec);
      end
      checks++;
      if (cout_s !== model_term(m_s, 1'b1)) begin
        failures++;
        $display("FAIL count_up_cout_sat step=%0d got=%b", i, cout_s);
      end
      m_w = model_next(m_w, 1'b1, 1'b1, 1'b1);
      m_s = model_next(m_s, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (out_w !== to_bcd(m_w) || out_s !== to_bcd(m_s)) begin
        failures++;
        $display("FAIL count_up_data step=%0d got=%h/%h exp=%h/%h",
                 i, out_w, out_s, to_bcd(m_w), to_bcd(m_s));
      end
    end
    $display("test_count_up: final DataOut=%h/%h", out_w, out_s);
  endtask

  task automatic test_load_down();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3F);
    @(negedge clk);
    checks++;
    if (cout_w !== 1'b0 || cout_s !== 1'b0) begin
      failures++;
      $display("FAIL load_cout got=%b/%b exp=0/0", cout_w, cout_s);
    end
    @(posedge clk); #1;
    m_w = 39; m_s = 39;
    checks++;
    if (out_w !== 8'h39 || out_s !== 8'h39) begin
      failures++;
      $display("FAIL load_clamp got=%h/%h exp=39", out_w, out_s);
    end
    $display("test_load: DataOut=%h", out_w);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      m_w = model_next(m_w, 1'b1, 1'b0, 1'b1);
      m_s = model_next(m_s, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_w !== to_bcd(m_w) || out_s !== to_bcd(m_s)) begin
        failures++;
        $display("FAIL load_down got=%h/%h exp=%h", out_w, out_s, to_bcd(m_w));
      end
      $display("test_load_down: DataOut=%h", out_w);
    end
  endtask

  task automatic test_terminal_down();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    @(posedge clk); #1;
    m_w = 0; m_s = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checks++;
    if (cout_w !== 1'b1 || cout_s !== 1'b1) begin
      failures++;
      $display("FAIL borrow_cout got=%b/%b exp=1/1", cout_w, cout_s);
    end
    @(posedge clk); #1;
    m_w = model_next(m_w, 1'b1, 1'b0, 1'b1);
    m_s = model_next(m_s, 1'b0, 1'b0, 1'b1);
    checks++;
    if (out_w !== to_bcd(m_w)) begin
      failures++;
      $display("FAIL borrow_wrap got=%h exp=%h", out_w, to_bcd(m_w));
    end
    checks++;
    if (out_s !== to_bcd(m_s)) begin
      failures++;
      $display("FAIL borrow_sat got=%h exp=%h", out_s, to_bcd(m_s));
    end
    $display("test_terminal_down: DataOut=%h/%h", out_w, out_s);
  endtask

  task automatic test_trigger_cin();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    @(posedge clk); #1;
    m_w = 0; m_s = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      m_w = model_next(m_w, 1'b1, 1'b1, 1'b1);
      m_s = model_next(m_s, 1'b0, 1'b1, 1'b1);
    end
    checks++;
    if (out_w !== 8'h05 || out_s !== to_bcd(m_s)) begin
      failures++;
      $display("FAIL trig_cin_single got=%h/%h exp=05/%h", out_w, out_s, to_bcd(m_s));
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h42);
    @(posedge clk); #1;
    m_w = 42; m_s = 42;
    checks++;
    if (out_w !== 8'h42 || out_s !== 8'h42) begin
      failures++;
      $display("FAIL load_wins got=%h/%h exp=42", out_w, out_s);
    end
    $display("test_trigger_cin: DataOut=%h", out_w);
  endtask

  task automatic test_chain();
    int cv;
    c_rst_n = 1'b0; c_trig = 1'b1;
    @(posedge clk); #1;
    cv = 0;
    c_rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checks++;
      if (lo_cout !== (cv % 10 == 9)) begin
        failures++;
        $display("FAIL chain_carry step=%0d got=%b", i, lo_cout);
      end
      @(posedge clk); #1;
      cv = (cv + 1) % 100;
      checks++;
      if ({hi_out, lo_out} !== to_bcd(cv)) begin
        failures++;
        $display("FAIL chain_value step=%0d got=%h exp=%h", i, {hi_out, lo_out}, to_bcd(cv));
      end
    end
    checks++;
    if ({hi_out, lo_out} !== 8'h25) begin
      failures++;
      $display("FAIL chain_25 got=%h exp=25", {hi_out, lo_out});
    end
    $display("test_chain: combined=%h", {hi_out, lo_out});
    c_rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (lo_cout !== 1'b0 || hi_cout !== 1'b0) begin
      failures++;
      $display("FAIL chain_reset_cout got=%b/%b exp=0/0", lo_cout, hi_cout);
    end
    @(posedge clk); #1;
    checks++;
    if (lo_out !== 4'h0 || hi_out !== 4'h0) begin
      failures++;
      $display("FAIL chain_reset got=%h%h exp=00", hi_out, lo_out);
    end
    $display("test_chain_reset: combined=%h", {hi_out, lo_out});
    c_rst_n = 1'b1; c_trig = 1'b0;
  endtask

  task automatic test_random();
    logic       r, t, c, u, l;
    logic [7:0] d;
    bit         ecw, ecs, stp;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(15) != 0);
      t = $urandom_range(1);
      c = ($urandom_range(3) == 0);
      u = $urandom_range(1);
      l = ($urandom_range(7) == 0);
      d = 8'($urandom);
      drive(r, t, c, u, l, d);
      stp = (t | c) & ~l;
      if (!r) begin
        ecw = 1'b0; ecs = 1'b0;
      end else begin
        ecw = stp & model_term(m_w, u);
        ecs = stp & model_term(m_s, u);
      end
      @(negedge clk);
      checks++;
      if (cout_w !== ecw || cout_s !== ecs) begin
        failures++;
        $display("FAIL rand_cout i=%0d got=%b/%b exp=%b/%b", i, cout_w, cout_s, ecw, ecs);
      end
      if (!r) begin
        m_w = 0; m_s = 0;
      end else if (l) begin
        m_w = load_value(d); m_s = load_value(d);
      end else begin
        m_w = model_next(m_w, 1'b1, u, stp);
        m_s = model_next(m_s, 1'b0, u, stp);
      end
      @(posedge clk); #1;
      checks++;
      if (out_w !== to_bcd(m_w) || out_s !== to_bcd(m_s)) begin
        failures++;
        $display("FAIL rand_data i=%0d got=%h/%h exp=%h/%h",
                 i, out_w, out_s, to_bcd(m_w), to_bcd(m_s));
      end
    end
    $display("test_random: 400 cycles, final DataOut=%h/%h", out_w, out_s);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    c_rst_n = 1'b0; c_trig = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_count_up();
    test_load_down();
    test_terminal_down();
    test_trigger_cin();
    test_chain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
